mux_3_to_1_bus_8_arb: RTL and testbench
=======================================

Name: mux_3_to_1_bus_8_arb

Overview:
Collects 8-bit words from three source channels onto one shared output bus. This is the gather-side counterpart to the 1-to-3 bus demultiplexer. Channels are granted round-robin, with bounded bursts and valid/ready handshakes on every channel. Each output word is tagged with its source code, which uses the same encoding as the demux sel (00/01/10), so downstream logic can route a reply back through the demux.

Parameters:
WIDTH, 8, data width of every channel and of the output bus
BURST_MAX, 4, maximum consecutive beats accepted from one channel per grant (legal range 1..15)

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  reset, synchronous, active-low
in1_data  input  WIDTH  channel 1 data (source code 2'b00)
in1_valid  input  1  channel 1 word available
in1_ready  output  1  channel 1 word accepted this cycle when valid&ready
in2_data / in2_valid / in2_ready  as channel 1, source code 2'b01
in3_data / in3_valid / in3_ready  as channel 1, source code 2'b10
out_data  output  WIDTH  registered output word
out_src  output  2  registered source code of out_data
out_valid  output  1  out_data/out_src hold a word
out_ready  input  1  downstream accepts the word when out_valid&out_ready

Behaviour:
- Reset (rst_n low at posedge):
  - out_valid=0, out_data=0, out_src=2'b00.
  - State IDLE, grant=2'b00, last_grant=2'b10 (channel 1 has first priority), beat_cnt=0.
  - Reset overrides all other activity, including mid-burst and while out_valid=1; the held word is dropped.
- Output register:
  - can_load = !out_valid || out_ready.
  - A transfer occurs when state==GRANT, the granted channel is valid, and can_load is true.
  - On a transfer, out_data and out_src are loaded and out_valid=1.
  - Otherwise, if out_ready=1 the output is cleared (out_valid=0); out_data and out_src hold their value.
- Ready generation (combinational):
  - inX_ready = (state==GRANT) && (grant==X) && can_load.
  - At most one ready is high in any cycle; all readies are 0 in IDLE and during reset.
- FSM states:
  - IDLE: if any in*_valid, select the first requesting channel in order last_grant+1, +2, +3 (mod 3). Register it into grant, clear beat_cnt, and go to GRANT. If nothing is requesting, stay in IDLE.
  - GRANT, transfer with beat_cnt==BURST_MAX-1: set last_grant=grant and go to IDLE.
  - GRANT, transfer otherwise: beat_cnt+1, stay in GRANT.
  - GRANT, granted channel valid=0: set last_grant=grant and go to IDLE (early release). No transfer occurs that cycle.
  - GRANT, granted channel valid=1 and can_load=0 (backpressure): hold everything; beat_cnt is unchanged.
- Latency:
  - in_valid rising in IDLE gives out_valid 2 cycles later (arbitrate, then transfer).
  - Back-to-back beats within a burst sustain 1 word/cycle.
  - Each channel switch costs exactly one bubble cycle (the IDLE cycle).
- Fairness: with all channels saturated, the output sequence is BURST_MAX words from each channel, in the rotation 00,01,10,00,...
- out_src=2'b11 is never produced.
- Input stability: a source must hold its data stable while valid&&!ready. The block does not check this.
- Simultaneous events: a new request arriving on another channel during GRANT does not pre-empt the current burst.

Decomposition:
- Package mux_bus_pkg:
  - state typedef {IDLE, GRANT}.
  - Source-code constants SRC_CH1=2'b00, SRC_CH2=2'b01, SRC_CH3=2'b10, shared with the demux sel encoding.
  - Beat-counter width constant of 4 bits.
- One natural sub-module, rr_arbiter_3:
  - Purely combinational.
  - Inputs: 3-bit request vector and last_grant.
  - Outputs: next_grant and any_req.
  - Instantiated once, used in IDLE.
- FSM, counter and output register live in the top module.

Test Plan:
1. Hold rst_n=0 for 2 cycles with all valids=1 and out_ready=1 -> out_valid=0 and all readies 0 during reset; after release, the first output word has out_src=2'b00.
2. Only in2_valid=1 with in2_data=8'hA5, out_ready=1, starting in IDLE at cycle 0 -> in2_ready=1 in cycle 1; out_valid=1, out_data=8'hA5, out_src=2'b01 in cycle 2.
3. All three channels saturated, incrementing data, BURST_MAX=4, out_ready=1 -> out_src sequence 00x4, bubble, 01x4, bubble, 10x4, bubble, 00x4; no word lost or duplicated.
4. Mid-burst out_ready=0 for 3 cycles -> out_data/out_src/out_valid stable, granted inX_ready=0, beat_cnt frozen; after out_ready returns, the burst completes with the correct remaining count.
5. Channel 3 granted, sends 2 words then drops valid while channel 1 is requesting -> FSM returns to IDLE; next grant is channel 1 (out_src=2'b00); beat_cnt restarts at 0.
6. rst_n=0 for one cycle mid-burst with out_valid=1 and out_ready=0 -> next cycle out_valid=0, state IDLE, held word dropped; arbitration restarts with channel 1 priority.

Source files
------------

// File: rtl/mux_bus_pkg.sv
// ---------------------------------------------------------------------------
// mux_bus_pkg
// Shared types and constants for the 3-to-1 bus gather block.
//   state_e      : arbitration FSM states (IDLE / GRANT)
//   SRC_CH1..3   : source codes tagged onto output words; identical to the
//                  1-to-3 demux sel encoding so replies can be routed back
//   BEAT_W       : width of the per-grant beat counter
//   rr_next()    : round-robin successor of a source code (mod 3)
// ---------------------------------------------------------------------------
package mux_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SRC_CH1 = 2'b00;
  localparam logic [1:0] SRC_CH2 = 2'b01;
  localparam logic [1:0] SRC_CH3 = 2'b10;

  localparam int unsigned BEAT_W = 4;

  // Successor in the rotation 00 -> 01 -> 10 -> 00. The unused code 11 maps
  // to channel 1 so a corrupted last_grant still yields a legal rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    logic [1:0] nxt;
    case (src)
      SRC_CH1: nxt = SRC_CH2;
      SRC_CH2: nxt = SRC_CH3;
      default: nxt = SRC_CH1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mux_3_to_1_bus_8_arb_rr_arbiter_3.sv
// ---------------------------------------------------------------------------
// rr_arbiter_3
// Purely combinational 3-way round-robin selector.
//   req        : request vector, bit 0 = channel 1 (source code 00)
//   last_grant : source code of the channel served most recently
//   next_grant : first requesting channel after last_grant in rotation order
//   any_req    : at least one channel is requesting
// ---------------------------------------------------------------------------
module rr_arbiter_3
  import mux_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] next_grant,
  output logic       any_req
);

  logic [1:0] cand1_s;
  logic [1:0] cand2_s;
  logic [1:0] cand3_s;

  // Walk the rotation starting just after last_grant; the third candidate is
  // last_grant itself, so a lone requester is always re-granted.
  always_comb begin
    cand1_s    = rr_next(last_grant);
    cand2_s    = rr_next(cand1_s);
    cand3_s    = rr_next(cand2_s);
    any_req    = |req;
    next_grant = SRC_CH1;
    if (req[cand1_s]) begin
      next_grant = cand1_s;
    end else if (req[cand2_s]) begin
      next_grant = cand2_s;
    end else if (req[cand3_s]) begin
      next_grant = cand3_s;
    end else begin
      next_grant = SRC_CH1;
    end
  end

endmodule

// File: rtl/mux_3_to_1_bus_8_arb.sv
// ---------------------------------------------------------------------------
// mux_3_to_1_bus_8_arb
// Gathers WIDTH-bit words from three valid/ready channels onto one registered
// output bus. Channels are served round-robin in bursts of up to BURST_MAX
// beats; each output word carries its source code (00/01/10).
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   inN_data/inN_valid/inN_ready   : source channels N=1..3 (codes 00/01/10)
//   out_data/out_src/out_valid     : registered output word and its source
//   out_ready                      : downstream accepts when valid&ready
// ---------------------------------------------------------------------------
module mux_3_to_1_bus_8_arb
  import mux_bus_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_valid,
  output logic             in2_ready,
  input  logic [WIDTH-1:0] in3_data,
  input  logic             in3_valid,
  output logic             in3_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

  state_e             state_q,      state_d;
  logic [1:0]         grant_q,      grant_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]  beat_cnt_q,   beat_cnt_d;
  logic [WIDTH-1:0]   out_data_q,   out_data_d;
  logic [1:0]         out_src_q,    out_src_d;
  logic               out_valid_q,  out_valid_d;

  logic [1:0]         arb_grant_s;
  logic               arb_any_s;
  logic               can_load_s;
  logic               gnt_valid_s;
  logic [WIDTH-1:0]   gnt_data_s;
  logic               transfer_s;

  rr_arbiter_3 u_arb (
    .req        ({in3_valid, in2_valid, in1_valid}),
    .last_grant (last_grant_q),
    .next_grant (arb_grant_s),
    .any_req    (arb_any_s)
  );

  // Route the granted channel's valid and data to the transfer logic.
  always_comb begin
    case (grant_q)
      SRC_CH1: begin gnt_valid_s = in1_valid; gnt_data_s = in1_data; end
      SRC_CH2: begin gnt_valid_s = in2_valid; gnt_data_s = in2_data; end
      SRC_CH3: begin gnt_valid_s = in3_valid; gnt_data_s = in3_data; end
      default: begin gnt_valid_s = 1'b0;      gnt_data_s = '0;       end
    endcase
  end

  assign can_load_s = !out_valid_q || out_ready;
  assign transfer_s = (state_q == GRANT) && gnt_valid_s && can_load_s;

  // Readies are gated by rst_n so nothing is accepted in a reset cycle even
  // though the state register only clears at the following edge.
  assign in1_ready = rst_n && (state_q == GRANT) && (grant_q == SRC_CH1) && can_load_s;
  assign in2_ready = rst_n && (state_q == GRANT) && (grant_q == SRC_CH2) && can_load_s;
  assign in3_ready = rst_n && (state_q == GRANT) && (grant_q == SRC_CH3) && can_load_s;

  // Arbitration FSM: next state, grant, rotation pointer and beat counter.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          grant_d    = arb_grant_s;
          beat_cnt_d = BEAT_ZERO;
          state_d    = GRANT;
        end else begin
          state_d    = IDLE;
        end
      end
      GRANT: begin
        if (!gnt_valid_s) begin
          // Early release: the granted source has nothing more to send.
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (can_load_s) begin
          if (beat_cnt_q == BEAT_LAST) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            beat_cnt_d   = beat_cnt_q + BEAT_ONE;
          end
        end else begin
          // Backpressure: hold grant and beat count.
          state_d      = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: load on transfer, drain when downstream takes the word.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (transfer_s) begin
      out_data_d  = gnt_data_s;
      out_src_d   = grant_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= SRC_CH1;
      last_grant_q <= SRC_CH3;
      beat_cnt_q   <= BEAT_ZERO;
      out_data_q   <= '0;
      out_src_q    <= SRC_CH1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_3_to_1_bus_8_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_3_to_1_bus_8_arb
// Directed, table-driven bench for mux_3_to_1_bus_8_arb. Each vector gives
// one cycle of inputs and the outputs expected in that cycle. Channel data
// comes from per-channel sources that present base+count and advance the
// count whenever the word is accepted.
// ---------------------------------------------------------------------------
module tb_mux_3_to_1_bus_8_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in1_data, in2_data, in3_data;
  logic       in1_valid, in2_valid, in3_valid;
  logic       in1_ready, in2_ready, in3_ready;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] base [3];
  int         cnt  [3];

  typedef struct {
    logic       rst_n;
    logic [2:0] v;      // bit0 = ch1
    logic       ordy;
    logic       chk;    // compare out_* this cycle
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
    logic [2:0] rdy;    // bit0 = in1_ready
  } vec_t;

  vec_t tbl [$];

  mux_3_to_1_bus_8_arb #(.WIDTH(8), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in2_data  (in2_data),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .in3_data  (in3_data),
    .in3_valid (in3_valid),
    .in3_ready (in3_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic o,
                              input logic c, input logic ov, input logic [7:0] d,
                              input logic [1:0] s, input logic [2:0] rdy);
    vec_t t;
    t.rst_n = r; t.v = v; t.ordy = o; t.chk = c;
    t.ov = ov; t.od = d; t.os = s; t.rdy = rdy;
    return t;
  endfunction

  task automatic set_bases(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    base[0] = b1; base[1] = b2; base[2] = b3;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
  endtask

  // One cycle: drive, check just after, clock, advance accepted sources.
  task automatic step(input vec_t t, input string name, input int idx);
    logic [2:0] rdy;
    logic [2:0] acc;
    rst_n     = t.rst_n;
    in1_valid = t.v[0];
    in2_valid = t.v[1];
    in3_valid = t.v[2];
    out_ready = t.ordy;
    in1_data  = base[0] + 8'(cnt[0]);
    in2_data  = base[1] + 8'(cnt[1]);
    in3_data  = base[2] + 8'(cnt[2]);
    #1;
    rdy = {in3_ready, in2_ready, in1_ready};
    checks++;
    if (rdy !== t.rdy) begin
      failures++;
      $display("FAIL %s[%0d] ready got=%b exp=%b", name, idx, rdy, t.rdy);
    end
    if (t.chk) begin
      checks++;
      if (out_valid !== t.ov) begin
        failures++;
        $display("FAIL %s[%0d] out_valid got=%b exp=%b", name, idx, out_valid, t.ov);
      end
      checks++;
      if (out_data !== t.od) begin
        failures++;
        $display("FAIL %s[%0d] out_data got=%h exp=%h", name, idx, out_data, t.od);
      end
      checks++;
      if (out_src !== t.os) begin
        failures++;
        $display("FAIL %s[%0d] out_src got=%b exp=%b", name, idx, out_src, t.os);
      end
    end
    acc = rdy & t.v;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i]) cnt[i]++;
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], name, i);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in1_valid = 1'b0; in2_valid = 1'b0; in3_valid = 1'b0;
    in1_data = 8'h00; in2_data = 8'h00; in3_data = 8'h00;

    // Reset with all valids high, then first word from ch1; single ch2 latency.
    set_bases(8'h11, 8'hA5, 8'h33);
    tbl.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 8'h11, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h11, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h11, 2'b00, 3'b010));
    tbl.push_back(mk(1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 8'hA5, 2'b01, 3'b010));
    tbl.push_back(mk(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 8'hA5, 2'b01, 3'b000));
    run_tbl("reset_single");

    // All channels saturated: 4 beats per channel, one bubble per switch.
    set_bases(8'h10, 8'h50, 8'h90);
    tbl.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000));
    for (int c = 0; c < 22; c++) begin
      logic [2:0] rdy;
      logic       ov;
      logic [7:0] d;
      logic [1:0] s;
      int g, q, g2, k, ch;
      g   = (c / 5) % 3;
      rdy = ((c % 5) == 0) ? 3'b000 : (3'b001 << g);
      if (c < 2) begin
        ov = 1'b0; d = 8'h00; s = 2'b00;
      end else begin
        q  = c - 2;
        g2 = q / 5;
        k  = q % 5;
        ch = g2 % 3;
        ov = (k != 4);
        d  = base[ch] + 8'(((g2 / 3) * 4) + ((k == 4) ? 3 : k));
        s  = 2'(ch);
      end
      tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, ov, d, s, rdy));
    end
    run_tbl("saturated");

    // Backpressure for 3 cycles mid-burst on ch2; burst still totals 4 beats.
    set_bases(8'h00, 8'h60, 8'h00);
    tbl.push_back(mk(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b010));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 8'h60, 2'b01, 3'b010));
    tbl.push_back(mk(1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 8'h61, 2'b01, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 8'h61, 2'b01, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 8'h61, 2'b01, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 8'h61, 2'b01, 3'b010));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 8'h62, 2'b01, 3'b010));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 8'h63, 2'b01, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h63, 2'b01, 3'b010));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 8'h64, 2'b01, 3'b010));
    run_tbl("backpressure");

    // Ch3 sends 2 words then drops valid; ch1 then gets a full fresh burst.
    set_bases(8'h20, 8'h00, 8'hC0);
    tbl.push_back(mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b100));
    tbl.push_back(mk(1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 8'hC0, 2'b10, 3'b100));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'hC1, 2'b10, 3'b100));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 8'hC1, 2'b10, 3'b000));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 8'hC1, 2'b10, 3'b001));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'h20, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'h21, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'h22, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 8'h23, 2'b00, 3'b000));
    run_tbl("early_release");

    // Reset mid-burst (ch2) while a word is held under backpressure.
    set_bases(8'h30, 8'h70, 8'hB0);
    tbl.push_back(mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b010));
    tbl.push_back(mk(1'b0, 3'b111, 1'b0, 1'b1, 1'b1, 8'h70, 2'b01, 3'b000));
    tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b000));
    tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 3'b001));
    tbl.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 8'h30, 2'b00, 3'b001));
    run_tbl("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
